// File: rtl/key_step_pkg.sv
// Shared definitions for the push-button step-pulse front end: FSM state
// encoding and default timing constants for a 100 MHz system clock.
package key_step_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    // 10 ms debounce window, 0.5 s before auto-repeat, then 5 steps per second
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_CNT_W           = 20;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 20000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/key_step_pulse.sv
// Bouncing push-button to single-cycle step pulse, with debounced level and a
// modulo-256 step counter. Define KEY_STEP_AUTOREPEAT_EN to add hold-to-repeat.
module key_step_pulse
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       step_pulse,
    output logic       key_level,
    output logic [7:0] step_count
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
    end

    logic key_s;

    sync_2ff u_sync (
        .clk   (CLK),
        .rst_n (rst_n),
        .d     (key_in),
        .q     (key_s)
    );

    key_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             step_pulse_d, step_pulse_q;
    logic             key_level_d, key_level_q;
    logic [7:0]       step_count_d, step_count_q;

`ifdef KEY_STEP_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_cnt_d, rpt_cnt_q;
    logic             rpt_first_d, rpt_first_q;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_pulse_d = 1'b0;
        step_count_d = step_count_q;

        case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = HELD;
                    step_pulse_d = 1'b1;
                    step_count_d = step_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef KEY_STEP_AUTOREPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        // Any cycle not spent staying in HELD rearms the long initial delay.
        if (state_q != HELD || state_d != HELD) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end else if (rpt_cnt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
            step_pulse_d = 1'b1;
            step_count_d = step_count_q + 8'd1;
            rpt_cnt_d    = '0;
            rpt_first_d  = 1'b0;
        end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
`endif

        key_level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            step_pulse_q <= 1'b0;
            key_level_q  <= 1'b0;
            step_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_pulse_q <= step_pulse_d;
            key_level_q  <= key_level_d;
            step_count_q <= step_count_d;
        end
    end

`ifdef KEY_STEP_AUTOREPEAT_EN
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
        end
    end
`endif

    assign step_pulse = step_pulse_q;
    assign key_level  = key_level_q;
    assign step_count = step_count_q;

endmodule
